// File: rtl/snoop_bus_arbiter_pkg.sv
// Shared message codes and FSM state encoding for the snooping bus arbiter,
// emitters and receivers.
package snoop_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    MSG_NONE       = 2'b00,
    MSG_READ_MISS  = 2'b01,
    MSG_WRITE_MISS = 2'b10,
    MSG_INVALIDATE = 2'b11
  } msg_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_BROADCAST = 2'b01,
    ST_WAIT_WB   = 2'b10,
    ST_DONE      = 2'b11
  } state_e;

endpackage

// File: rtl/snoop_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after the
// priority pointer, wrapping modulo N_REQ.
module snoop_bus_arbiter_rr_picker #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [N_REQ-1:0]         grant_o,
  output logic [$clog2(N_REQ)-1:0] idx_o,
  output logic                     any_o
);

  localparam int unsigned SRC_W = $clog2(N_REQ);

  logic [SRC_W-1:0] cand;
  logic             found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = SRC_W'((32'(ptr_i) + k) % N_REQ);
      if (!found && req_i[cand]) begin
        found          = 1'b1;
        idx_o          = cand;
        grant_o[cand]  = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Round-robin owner of the snooping coherence bus: latches the winner's message,
// broadcasts it, waits out dirty-copy write-backs, then signals completion.
module snoop_bus_arbiter
  import snoop_bus_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned WB_TIMEOUT = 15
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset,
  input  logic [N_REQ-1:0]          i_Req,
  input  logic [2*N_REQ-1:0]        i_Msg,
  input  logic [ADDR_W*N_REQ-1:0]   i_Addr,
  input  logic [N_REQ-1:0]          i_SnoopAbort,
  input  logic [N_REQ-1:0]          i_WbDone,
  output logic [N_REQ-1:0]          o_Grant,
  output logic [N_REQ-1:0]          o_Done,
  output logic                      o_BusValid,
  output logic [1:0]                o_BusMsg,
  output logic [ADDR_W-1:0]         o_BusAddr,
  output logic [$clog2(N_REQ)-1:0]  o_BusSrc,
  output logic                      o_Timeout
);

  localparam int unsigned SRC_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(WB_TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [SRC_W-1:0]    prio_q, prio_d;
  logic [SRC_W-1:0]    src_q, src_d;
  msg_e                msg_q, msg_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [N_REQ-1:0]    mask_q, mask_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [N_REQ-1:0]    done_q, done_d;
  logic                valid_q, valid_d;
  logic                timeout_q, timeout_d;

  logic [N_REQ-1:0]    elig_c;
  logic [N_REQ-1:0]    pick_onehot_c;
  logic [SRC_W-1:0]    pick_idx_c;
  logic                pick_any_c;
  msg_e                msg_sel_c;
  logic [ADDR_W-1:0]   addr_sel_c;
  logic [N_REQ-1:0]    abort_mask_c;
  logic [N_REQ-1:0]    wb_left_c;
  logic                wb_expire_c;

  // A request carrying NONE is never eligible for the bus.
  always_comb begin
    elig_c = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      elig_c[i] = i_Req[i] && (i_Msg[2*i +: 2] != 2'(MSG_NONE));
    end
  end

  snoop_bus_arbiter_rr_picker #(.N_REQ(N_REQ)) u_rr_picker (
    .req_i   (elig_c),
    .ptr_i   (prio_q),
    .grant_o (pick_onehot_c),
    .idx_o   (pick_idx_c),
    .any_o   (pick_any_c)
  );

  always_comb begin
    msg_sel_c  = MSG_NONE;
    addr_sel_c = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (pick_idx_c == SRC_W'(i)) begin
        msg_sel_c  = msg_e'(i_Msg[2*i +: 2]);
        addr_sel_c = i_Addr[ADDR_W*i +: ADDR_W];
      end
    end
  end

  assign abort_mask_c = i_SnoopAbort & ~(N_REQ'(1) << src_q);
  assign wb_left_c    = mask_q & ~i_WbDone;
  assign wb_expire_c  = (cnt_q == CNT_W'(WB_TIMEOUT - 1));

  // State and datapath registers.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= ST_IDLE;
      prio_q    <= '0;
      src_q     <= '0;
      msg_q     <= MSG_NONE;
      addr_q    <= '0;
      mask_q    <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      src_q     <= src_d;
      msg_q     <= msg_d;
      addr_q    <= addr_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (pick_any_c) state_d = ST_BROADCAST;
      ST_BROADCAST: state_d = (|abort_mask_c) ? ST_WAIT_WB : ST_DONE;
      ST_WAIT_WB: begin
        if (wb_left_c == '0)  state_d = ST_BROADCAST;
        else if (wb_expire_c) state_d = ST_DONE;
      end
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered-output next values; the timeout pulse lands with DONE.
  always_comb begin
    prio_d    = prio_q;
    src_d     = src_q;
    msg_d     = msg_q;
    addr_d    = addr_q;
    mask_d    = mask_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    done_d    = '0;
    valid_d   = (state_d == ST_BROADCAST);
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any_c) begin
          src_d   = pick_idx_c;
          msg_d   = msg_sel_c;
          addr_d  = addr_sel_c;
          grant_d = pick_onehot_c;
        end
      end
      ST_BROADCAST: begin
        if (|abort_mask_c) begin
          mask_d = abort_mask_c;
          cnt_d  = '0;
        end
      end
      ST_WAIT_WB: begin
        mask_d    = wb_left_c;
        cnt_d     = cnt_q + CNT_W'(1);
        timeout_d = (wb_left_c != '0) && wb_expire_c;
      end
      ST_DONE: begin
        grant_d = '0;
        prio_d  = (src_q == SRC_W'(N_REQ - 1)) ? '0 : src_q + SRC_W'(1);
      end
      default: ;
    endcase
    if (state_d == ST_DONE) done_d = N_REQ'(1) << src_q;
  end

  assign o_Grant    = grant_q;
  assign o_Done     = done_q;
  assign o_BusValid = valid_q;
  assign o_BusMsg   = msg_q;
  assign o_BusAddr  = addr_q;
  assign o_BusSrc   = src_q;
  assign o_Timeout  = timeout_q;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed self-checking bench for snoop_bus_arbiter (N_REQ=4, ADDR_W=8, WB_TIMEOUT=15).
module tb_snoop_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, abort, wbd;
  logic [7:0]  msg;
  logic [31:0] addr;
  logic [3:0]  grant, done;
  logic        valid, tmo;
  logic [1:0]  bmsg, bsrc;
  logic [7:0]  baddr;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  snoop_bus_arbiter #(.N_REQ(4), .ADDR_W(8), .WB_TIMEOUT(15)) dut (
    .i_Clock      (clk),
    .i_Reset      (rst),
    .i_Req        (req),
    .i_Msg        (msg),
    .i_Addr       (addr),
    .i_SnoopAbort (abort),
    .i_WbDone     (wbd),
    .o_Grant      (grant),
    .o_Done       (done),
    .o_BusValid   (valid),
    .o_BusMsg     (bmsg),
    .o_BusAddr    (baddr),
    .o_BusSrc     (bsrc),
    .o_Timeout    (tmo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'hF; msg = 8'h55; addr = 32'h44332211; abort = '0; wbd = '0;
    repeat (2) begin
      tick();
      tests_run++; if (grant !== 4'b0000) begin tests_failed++; $display("FAIL reset_grant: got %b want 0000", grant); end
      tests_run++; if (done !== 4'b0000) begin tests_failed++; $display("FAIL reset_done: got %b want 0000", done); end
      tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", valid); end
      tests_run++; if (bmsg !== 2'b00 || baddr !== 8'h00 || bsrc !== 2'd0) begin tests_failed++; $display("FAIL reset_bus: got msg %b addr %h src %0d want 0/0/0", bmsg, baddr, bsrc); end
      tests_run++; if (tmo !== 1'b0) begin tests_failed++; $display("FAIL reset_timeout: got %b want 0", tmo); end
    end
    rst = 1'b0; req = '0;
    tick();
    tests_run++; if (grant !== 4'b0000 || valid !== 1'b0) begin tests_failed++; $display("FAIL reset_release: got grant %b valid %b want 0000/0", grant, valid); end
  endtask

  task automatic test_single();
    req = 4'b0100; msg = 8'b00_10_00_00; addr = 32'h003C_0000;
    tick();
    tests_run++; if (grant !== 4'b0100) begin tests_failed++; $display("FAIL single_grant: got %b want 0100", grant); end
    tests_run++; if (valid !== 1'b1) begin tests_failed++; $display("FAIL single_valid: got %b want 1", valid); end
    tests_run++; if (bmsg !== 2'b10 || baddr !== 8'h3C || bsrc !== 2'd2) begin tests_failed++; $display("FAIL single_bus: got msg %b addr %h src %0d want 10/3c/2", bmsg, baddr, bsrc); end
    tests_run++; if (done !== 4'b0000) begin tests_failed++; $display("FAIL single_done_early: got %b want 0000", done); end
    tick();
    tests_run++; if (done !== 4'b0100 || valid !== 1'b0 || grant !== 4'b0100) begin tests_failed++; $display("FAIL single_done: got done %b valid %b grant %b want 0100/0/0100", done, valid, grant); end
    req = '0;
    tick();
    tests_run++; if (grant !== 4'b0000 || done !== 4'b0000) begin tests_failed++; $display("FAIL single_idle: got grant %b done %b want 0000/0000", grant, done); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    rst = 1'b1;
    tick();
    rst = 1'b0; req = 4'hF; msg = 8'h55; addr = 32'h4030_2010;
    for (int n = 0; n < 4; n++) begin
      exp_g = 4'(1 << n);
      tick();
      tests_run++; if (grant !== exp_g || valid !== 1'b1) begin tests_failed++; $display("FAIL rr_grant%0d: got grant %b valid %b want %b/1", n, grant, valid, exp_g); end
      tests_run++; if (bsrc !== 2'(n) || baddr !== 8'((n + 1) * 16) || bmsg !== 2'b01) begin tests_failed++; $display("FAIL rr_bus%0d: got src %0d addr %h msg %b want %0d/%h/01", n, bsrc, baddr, bmsg, n, 8'((n + 1) * 16)); end
      tick();
      tests_run++; if (done !== exp_g) begin tests_failed++; $display("FAIL rr_done%0d: got %b want %b", n, done, exp_g); end
      req[n] = 1'b0;
      tick();
      tests_run++; if (grant !== 4'b0000 || valid !== 1'b0) begin tests_failed++; $display("FAIL rr_idle%0d: got grant %b valid %b want 0000/0", n, grant, valid); end
    end
    // Pointer wrapped back to 0: cache 0 beats cache 3.
    req = 4'b1001;
    tick();
    tests_run++; if (grant !== 4'b0001) begin tests_failed++; $display("FAIL rr_wrap: got %b want 0001", grant); end
    tick();
    tests_run++; if (done !== 4'b0001) begin tests_failed++; $display("FAIL rr_wrap_done: got %b want 0001", done); end
    req = '0;
    tick();
  endtask

  task automatic test_writeback_retry();
    req = 4'b0010; msg = 8'b00_00_01_00; addr = 32'h0000_1000;
    tick();
    tests_run++; if (grant !== 4'b0010 || valid !== 1'b1) begin tests_failed++; $display("FAIL wb_first_bcast: got grant %b valid %b want 0010/1", grant, valid); end
    abort = 4'b1010; wbd = 4'b1000;
    tick();
    tests_run++; if (valid !== 1'b0 || grant !== 4'b0010 || bmsg !== 2'b01 || baddr !== 8'h10) begin tests_failed++; $display("FAIL wb_wait1: got valid %b grant %b msg %b addr %h want 0/0010/01/10", valid, grant, bmsg, baddr); end
    abort = '0; wbd = 4'b0001;
    tick();
    tests_run++; if (valid !== 1'b0 || done !== 4'b0000) begin tests_failed++; $display("FAIL wb_wait2: got valid %b done %b want 0/0000", valid, done); end
    wbd = '0;
    tick();
    tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL wb_wait3: got valid %b want 0", valid); end
    tick();
    tests_run++; if (valid !== 1'b0 || grant !== 4'b0010) begin tests_failed++; $display("FAIL wb_wait4: got valid %b grant %b want 0/0010", valid, grant); end
    wbd = 4'b1000;
    tick();
    tests_run++; if (valid !== 1'b1 || bmsg !== 2'b01 || baddr !== 8'h10 || done !== 4'b0000) begin tests_failed++; $display("FAIL wb_rebcast: got valid %b msg %b addr %h done %b want 1/01/10/0000", valid, bmsg, baddr, done); end
    wbd = '0;
    tick();
    tests_run++; if (done !== 4'b0010 || tmo !== 1'b0) begin tests_failed++; $display("FAIL wb_done: got done %b timeout %b want 0010/0", done, tmo); end
    req = '0;
    tick();
    tests_run++; if (grant !== 4'b0000) begin tests_failed++; $display("FAIL wb_idle: got %b want 0000", grant); end
  endtask

  task automatic test_timeout();
    req = 4'b0100; msg = 8'b00_11_00_00; addr = 32'h00A5_0000;
    tick();
    tests_run++; if (grant !== 4'b0100 || valid !== 1'b1 || bmsg !== 2'b11) begin tests_failed++; $display("FAIL to_bcast: got grant %b valid %b msg %b want 0100/1/11", grant, valid, bmsg); end
    abort = 4'b0001;
    for (int c = 1; c <= 15; c++) begin
      tick();
      abort = '0;
      tests_run++; if (valid !== 1'b0 || tmo !== 1'b0 || done !== 4'b0000) begin tests_failed++; $display("FAIL to_wait%0d: got valid %b timeout %b done %b want 0/0/0000", c, valid, tmo, done); end
    end
    tick();
    tests_run++; if (tmo !== 1'b1 || done !== 4'b0100 || valid !== 1'b0) begin tests_failed++; $display("FAIL to_expire: got timeout %b done %b valid %b want 1/0100/0", tmo, done, valid); end
    req = '0;
    tick();
    tests_run++; if (tmo !== 1'b0 || grant !== 4'b0000 || done !== 4'b0000) begin tests_failed++; $display("FAIL to_idle: got timeout %b grant %b done %b want 0/0000/0000", tmo, grant, done); end
  endtask

  task automatic test_reset_mid_none();
    req = 4'b0011; msg = 8'b00_00_10_00; addr = 32'h0000_7700;
    tick();
    tests_run++; if (grant !== 4'b0010 || bsrc !== 2'd1) begin tests_failed++; $display("FAIL none_skip: got grant %b src %0d want 0010/1", grant, bsrc); end
    abort = 4'b0100;
    tick();
    tests_run++; if (valid !== 1'b0 || grant !== 4'b0010) begin tests_failed++; $display("FAIL mid_wait: got valid %b grant %b want 0/0010", valid, grant); end
    abort = '0; rst = 1'b1;
    tick();
    tests_run++; if (grant !== 4'b0000 || done !== 4'b0000 || valid !== 1'b0 || tmo !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_ctl: got grant %b done %b valid %b timeout %b want 0", grant, done, valid, tmo); end
    tests_run++; if (bmsg !== 2'b00 || baddr !== 8'h00 || bsrc !== 2'd0) begin tests_failed++; $display("FAIL mid_reset_bus: got msg %b addr %h src %0d want 0/0/0", bmsg, baddr, bsrc); end
    rst = 1'b0; req = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      tick();
      tests_run++; if (grant !== 4'b0000 || valid !== 1'b0) begin tests_failed++; $display("FAIL none_held%0d: got grant %b valid %b want 0000/0", c, grant, valid); end
    end
    req = 4'b1001; msg = 8'b01_00_00_00; addr = 32'h9900_0000;
    tick();
    tests_run++; if (grant !== 4'b1000 || bsrc !== 2'd3 || baddr !== 8'h99) begin tests_failed++; $display("FAIL none_vs_real: got grant %b src %0d addr %h want 1000/3/99", grant, bsrc, baddr); end
    tick();
    tests_run++; if (done !== 4'b1000) begin tests_failed++; $display("FAIL none_real_done: got %b want 1000", done); end
    req = 4'b0001;
    repeat (2) begin
      tick();
      tests_run++; if (grant !== 4'b0000) begin tests_failed++; $display("FAIL none_after: got %b want 0000", grant); end
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; msg = '0; addr = '0; abort = '0; wbd = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_writeback_retry();
    test_timeout();
    test_reset_mid_none();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
